// File: rtl/fpu_mul_pkg.sv
// fpu_mul_pkg: shared constants and types for the iterative
// 53x53 fraction multiplier (digit width, digit count, FSM states).
package fpu_mul_pkg;

  localparam int DIGIT_W         = 8;
  localparam int N_DIGITS        = 7;
  localparam int SNG_START_DIGIT = 3;
  localparam int FRAC_W          = 53;
  localparam int B_W             = N_DIGITS * DIGIT_W;
  localparam int PP_W            = FRAC_W + DIGIT_W;
  localparam int PROD_W          = 106;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/fpu_mul_53x8.sv
// fpu_mul_53x8: combinational 53x8 partial product.
// Ports: a (53b multiplicand), b (8b digit), p (61b product).
module fpu_mul_53x8
  import fpu_mul_pkg::*;
(
  input  logic [FRAC_W-1:0]  a,
  input  logic [DIGIT_W-1:0] b,
  output logic [PP_W-1:0]    p
);

  assign p = {{DIGIT_W{1'b0}}, a} * {{FRAC_W{1'b0}}, b};

endmodule

// File: rtl/fpu_mul_iter_array.sv
// fpu_mul_iter_array: iterative 53x53 fraction multiplier, one
// 8-bit multiplier digit per advancing cycle; frozen while
// m6stg_step=0.
// Ports: rclk, reset (sync, active high), m6stg_step (advance),
//   m1stg_mul_start/m1stg_mul_sng (request, single flag),
//   m2stg_frac1_array_in (A, inverted), m2stg_frac2_array_in (B),
//   mul_array_rdy, m4stg_frac (106b product), m4stg_frac_vld.
// Build option: FPU_MUL_SNG_FAST_EN starts single ops at digit 3
//   (4-cycle latency instead of 7).
module fpu_mul_iter_array
  import fpu_mul_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                m6stg_step,
  input  logic                m1stg_mul_start,
  input  logic                m1stg_mul_sng,
  input  logic [FRAC_W-1:0]   m2stg_frac1_array_in,
  input  logic [FRAC_W-1:0]   m2stg_frac2_array_in,
  output logic                mul_array_rdy,
  output logic [PROD_W-1:0]   m4stg_frac,
  output logic                m4stg_frac_vld
);

  typedef logic [N_DIGITS-1:0][DIGIT_W-1:0] b_digits_t;

  mul_state_e          state;
  mul_state_e          state_n;
  logic [FRAC_W-1:0]   a_q;
  b_digits_t           b_q;
  logic                sng_q;
  logic [2:0]          k;
  logic [2:0]          start_k;
  logic [PROD_W-1:0]   acc;
  logic [PP_W-1:0]     pp;
  logic [PROD_W-1:0]   pp_sh;
  logic                accept;
  logic                last_k;
  logic                unused_sng;

  assign mul_array_rdy = (state == IDLE) ||
                         (state == DONE && m6stg_step);
  assign accept = mul_array_rdy && m1stg_mul_start &&
                  m6stg_step;
  assign last_k = (k == 3'(N_DIGITS - 1));

`ifdef FPU_MUL_SNG_FAST_EN
  // single operands carry zeros in B[28:0]; skip digits 0-2
  assign start_k = m1stg_mul_sng ?
                   3'(SNG_START_DIGIT) : 3'd0;
`else
  assign start_k = 3'd0;
`endif

  // kept for downstream debug visibility, no consumer here
  assign unused_sng = sng_q;

  fpu_mul_53x8 u_pp (
    .a (a_q),
    .b (b_q[k]),
    .p (pp)
  );

  // true product fits in 106 bits, so upper shifted-out
  // bits of the last digits are always zero
  assign pp_sh = {{(PROD_W - PP_W){1'b0}}, pp} << {k, 3'b000};

  always_ff @(posedge rclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (m6stg_step && last_k) state_n = DONE;
      DONE: begin
        if (m6stg_step) state_n = accept ? BUSY : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      sng_q <= 1'b0;
      k     <= '0;
      acc   <= '0;
    end else if (accept) begin
      a_q   <= ~m2stg_frac1_array_in;
      b_q   <= {3'b000, m2stg_frac2_array_in};
      sng_q <= m1stg_mul_sng;
      k     <= start_k;
      acc   <= '0;
    end else if (m6stg_step && state == BUSY) begin
      acc <= acc + pp_sh;
      k   <= k + 3'd1;
    end
  end

  assign m4stg_frac     = acc;
  assign m4stg_frac_vld = (state == DONE);

endmodule

// File: tb/tb_fpu_mul_iter_array.sv
// tb_fpu_mul_iter_array: directed vector table plus stall,
// reset and back-to-back sequences for fpu_mul_iter_array.
module tb_fpu_mul_iter_array;

`ifdef FPU_MUL_SNG_FAST_EN
  localparam int N_SNG = 4;
`else
  localparam int N_SNG = 7;
`endif
  localparam int N_DBL = 7;
  localparam int NO_STALL = 100;

  logic          rclk = 1'b0;
  logic          reset;
  logic          step;
  logic          start;
  logic          sng;
  logic [52:0]   f1;
  logic [52:0]   f2;
  logic          rdy;
  logic [105:0]  frac;
  logic          vld;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [52:0]  a;
    logic [52:0]  b;
    logic         sng;
    logic [105:0] p;
    int           n;
  } vec_t;

  vec_t vt[8];

  always #5 rclk = ~rclk;

  fpu_mul_iter_array dut (
    .rclk                 (rclk),
    .reset                (reset),
    .m6stg_step           (step),
    .m1stg_mul_start      (start),
    .m1stg_mul_sng        (sng),
    .m2stg_frac1_array_in (f1),
    .m2stg_frac2_array_in (f2),
    .mul_array_rdy        (rdy),
    .m4stg_frac           (frac),
    .m4stg_frac_vld       (vld)
  );

  task automatic chk(input string nm,
                     input logic [105:0] act,
                     input logic [105:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic st);
    start = st;
    f1    = ~v.a;
    f2    = v.b;
    sng   = v.sng;
  endtask

  task automatic wait_vld(input int st_at, input int st_len,
                          output int edges);
    edges = 0;
    while (!vld && edges < 40) begin
      step = (edges >= st_at && edges < st_at + st_len) ?
             1'b0 : 1'b1;
      @(negedge rclk);
      edges++;
    end
    step = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input string nm,
                        input int st_at, input int st_len);
    int e;
    chk({nm, " rdy_idle"}, 106'(rdy), 106'd1);
    step = 1'b1;
    drive(v, 1'b1);
    @(negedge rclk);
    drive(vt[1], 1'b0);
    wait_vld(st_at, st_len, e);
    chk({nm, " latency"}, 106'(e), 106'(v.n + st_len));
    chk({nm, " product"}, frac, v.p);
    step = 1'b0;
    #1;
    chk({nm, " rdy_stall"}, 106'(rdy), 106'd0);
    repeat (2) @(negedge rclk);
    chk({nm, " hold_vld"}, 106'(vld), 106'd1);
    chk({nm, " hold_prod"}, frac, v.p);
    step = 1'b1;
    #1;
    chk({nm, " rdy_done"}, 106'(rdy), 106'd1);
    @(negedge rclk);
    chk({nm, " consumed"}, 106'(vld), 106'd0);
  endtask

  initial begin
    int e;
    vt[0] = '{53'h10000000000000, 53'h10000000000000, 1'b0,
              106'd1 << 104, N_DBL};
    vt[1] = '{53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 1'b0,
              ({106{1'b1}} << 54) | 106'd1, N_DBL};
    vt[2] = '{53'h18000000000000, 53'h18000000000000, 1'b1,
              106'd9 << 102, N_SNG};
    vt[3] = '{53'h18000000000000, 53'h14000000000000, 1'b0,
              106'd15 << 101, N_DBL};
    vt[4] = '{53'h1FFFFFFFFFFFFF, 53'h10000000000000, 1'b0,
              106'h1FFFFFFFFFFFFF << 52, N_DBL};
    vt[5] = '{53'h10000000000001, 53'h10000000000001, 1'b0,
              (106'd1 << 104) | (106'd1 << 53) | 106'd1,
              N_DBL};
    vt[6] = '{53'h10000000000000, 53'h100000000000A5, 1'b0,
              (106'd1 << 104) | (106'hA5 << 52), N_DBL};
    vt[7] = '{53'h10000000000000, 53'h1C000000000000, 1'b1,
              106'd7 << 102, N_SNG};

    reset = 1'b1;
    step  = 1'b0;
    start = 1'b0;
    sng   = 1'b0;
    f1    = '0;
    f2    = '0;
    repeat (2) @(negedge rclk);
    reset = 1'b0;
    chk("reset vld", 106'(vld), 106'd0);
    chk("reset frac", frac, 106'd0);
    chk("reset rdy", 106'(rdy), 106'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i], $sformatf("vec%0d", i), NO_STALL, 0);
    end

    run_op(vt[1], "stall", 3, 3);

    // reset during BUSY after three iterations, with a
    // simultaneous start that must be dropped
    step = 1'b1;
    drive(vt[1], 1'b1);
    @(negedge rclk);
    start = 1'b0;
    repeat (3) @(negedge rclk);
    reset = 1'b1;
    drive(vt[0], 1'b1);
    @(negedge rclk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_mid vld", 106'(vld), 106'd0);
    chk("rst_mid frac", frac, 106'd0);
    chk("rst_mid rdy", 106'(rdy), 106'd1);
    @(negedge rclk);
    chk("rst_mid idle", 106'(rdy), 106'd1);
    run_op(vt[5], "after_rst", NO_STALL, 0);

    // back-to-back with start held high; starts presented
    // while BUSY carry other operands and must be ignored
    step = 1'b1;
    drive(vt[0], 1'b1);
    @(negedge rclk);
    drive(vt[1], 1'b1);
    wait_vld(NO_STALL, 0, e);
    chk("b2b lat1", 106'(e), 106'd7);
    chk("b2b prod1", frac, vt[0].p);
    chk("b2b rdy", 106'(rdy), 106'd1);
    drive(vt[5], 1'b1);
    @(negedge rclk);
    chk("b2b consume", 106'(vld), 106'd0);
    drive(vt[1], 1'b1);
    wait_vld(NO_STALL, 0, e);
    chk("b2b lat2", 106'(e), 106'd7);
    chk("b2b prod2", frac, vt[5].p);
    start = 1'b0;
    @(negedge rclk);
    chk("b2b end", 106'(vld), 106'd0);
    chk("b2b idle", 106'(rdy), 106'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
